// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, funct codes, ALU op codes and the
// control bundle handed from decode to the ID/EX register.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;

   typedef struct packed {
      logic [3:0] aluc;
      logic       aluimm;
      logic       shift;
      logic       sext;
      logic       wreg;
      logic       m2reg;
      logic       wmem;
   } ctrl_t;

   function automatic ctrl_t mkCtrl(input logic [3:0] aluc, input logic aluimm,
                                    input logic shift, input logic sext,
                                    input logic wreg, input logic m2reg,
                                    input logic wmem);
      ctrl_t c;
      c.aluc   = aluc;
      c.aluimm = aluimm;
      c.shift  = shift;
      c.sext   = sext;
      c.wreg   = wreg;
      c.m2reg  = m2reg;
      c.wmem   = wmem;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: instruction word to ALU/operand control
// bundle, destination register and illegal flag. Shared with the hazard unit.
module ctrl_decode
   import mips_pkg::*;
#(
   parameter int RN_W = 5
) (
   input  logic [31:0]     inst_i,
   output ctrl_t           ctrl_o,
   output logic [RN_W-1:0] rn_o,
   output logic            illegal_o
);

   logic [5:0] opcode;
   logic [5:0] funct;

   assign opcode = inst_i[31:26];
   assign funct  = inst_i[5:0];

   // Unknown encodings leave the all-zero bundle: aluc=add, no writes.
   always_comb begin
      ctrl_o    = '0;
      illegal_o = 1'b0;
      rn_o      = RN_W'(inst_i[20:16]);
      case (opcode)
         OP_RTYPE: begin
            rn_o = RN_W'(inst_i[15:11]);
            case (funct)
               FN_ADD, FN_ADDU: ctrl_o = mkCtrl(ALUC_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SUB, FN_SUBU: ctrl_o = mkCtrl(ALUC_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_AND:          ctrl_o = mkCtrl(ALUC_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_OR:           ctrl_o = mkCtrl(ALUC_OR,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_XOR:          ctrl_o = mkCtrl(ALUC_XOR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SLL:          ctrl_o = mkCtrl(ALUC_SLL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SRL:          ctrl_o = mkCtrl(ALUC_SRL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
               FN_SRA:          ctrl_o = mkCtrl(ALUC_SRA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
               default:         illegal_o = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU: ctrl_o = mkCtrl(ALUC_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         OP_ANDI:           ctrl_o = mkCtrl(ALUC_AND, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_ORI:            ctrl_o = mkCtrl(ALUC_OR,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_XORI:           ctrl_o = mkCtrl(ALUC_XOR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_LUI:            ctrl_o = mkCtrl(ALUC_LUI, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         OP_LW:             ctrl_o = mkCtrl(ALUC_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         OP_SW:             ctrl_o = mkCtrl(ALUC_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         OP_BEQ, OP_BNE:    ctrl_o = mkCtrl(ALUC_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         default:           illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX control register: decodes the ID instruction and holds the ALU
// controls for EX under a valid/ready handshake with stall and flush.
module id_ex_ctrl
   import mips_pkg::*;
#(
   parameter int RN_W      = 5,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [31:0]          d_inst,
   input  logic                 d_valid,
   output logic                 d_ready,
   input  logic                 e_ready,
   input  logic                 flush,
   output logic                 e_valid,
   output logic [3:0]           e_aluc,
   output logic                 e_aluimm,
   output logic                 e_shift,
   output logic                 e_sext,
   output logic                 e_wreg,
   output logic                 e_m2reg,
   output logic                 e_wmem,
   output logic [RN_W-1:0]      e_rn,
   output logic                 e_illegal,
   output logic [ILL_CNT_W-1:0] ill_cnt
);

   ctrl_t                decCtrl;
   logic [RN_W-1:0]      decRn;
   logic                 decIllegal;

   ctrl_t                ctrl_q,    ctrl_d;
   logic [RN_W-1:0]      rn_q,      rn_d;
   logic                 valid_q,   valid_d;
   logic                 illegal_q, illegal_d;
   logic [ILL_CNT_W-1:0] illCnt_q,  illCnt_d;
   logic                 transfer;

   ctrl_decode #(.RN_W(RN_W)) u_decode (
      .inst_i    (d_inst),
      .ctrl_o    (decCtrl),
      .rn_o      (decRn),
      .illegal_o (decIllegal)
   );

   assign d_ready  = e_ready | ~valid_q;
   assign transfer = d_valid & d_ready;

   // Flush beats transfer so a killed instruction is neither latched nor
   // counted; fields not named in a bubble/flush keep their old value.
   always_comb begin
      ctrl_d    = ctrl_q;
      rn_d      = rn_q;
      valid_d   = valid_q;
      illegal_d = illegal_q;
      illCnt_d  = illCnt_q;
      if (flush) begin
         valid_d     = 1'b0;
         ctrl_d.wreg = 1'b0;
         ctrl_d.wmem = 1'b0;
         illegal_d   = 1'b0;
      end else if (transfer) begin
         valid_d   = 1'b1;
         ctrl_d    = decCtrl;
         rn_d      = decRn;
         illegal_d = decIllegal;
         if (decIllegal && (illCnt_q != '1)) begin
            illCnt_d = illCnt_q + ILL_CNT_W'(1);
         end
      end else if (e_ready && valid_q) begin
         valid_d     = 1'b0;
         ctrl_d.wreg = 1'b0;
         ctrl_d.wmem = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ctrl_q    <= '0;
         rn_q      <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         illCnt_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         rn_q      <= rn_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         illCnt_q  <= illCnt_d;
      end
   end

   assign e_valid   = valid_q;
   assign e_aluc    = ctrl_q.aluc;
   assign e_aluimm  = ctrl_q.aluimm;
   assign e_shift   = ctrl_q.shift;
   assign e_sext    = ctrl_q.sext;
   assign e_wreg    = ctrl_q.wreg;
   assign e_m2reg   = ctrl_q.m2reg;
   assign e_wmem    = ctrl_q.wmem;
   assign e_rn      = rn_q;
   assign e_illegal = illegal_q;
   assign ill_cnt   = illCnt_q;

endmodule
